// File: rtl/ov7670_init_pkg.sv
// Shared types, constants and the register table for the OV7670 power-up sequencer.
// Build option: OV7670_TEST_PATTERN_EN appends the colour-bar test pattern writes.
package ov7670_init_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_LOAD, S_XFER, S_GAP, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    W_IDLE, S_START, S_BIT, S_STOP
  } wr_state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } sccb_entry_t;

  localparam logic [7:0] SCCB_DEV_ID = 8'h42;
  localparam logic [7:0] DELAY_REG   = 8'hFF;
  localparam int         BASE_LEN    = 18;
  localparam int         IDX_W       = 5;
`ifdef OV7670_TEST_PATTERN_EN
  localparam int         TABLE_LEN   = BASE_LEN + 2;
`else
  localparam int         TABLE_LEN   = BASE_LEN;
`endif

  // Soft reset, settle marker, then RGB444 at VGA resolution.
  function automatic sccb_entry_t sccb_rom(input logic [IDX_W-1:0] idx);
    sccb_entry_t e;
    case (idx)
      5'd0:  e = {8'h12, 8'h80};
      5'd1:  e = {DELAY_REG, 8'hFF};
      5'd2:  e = {8'h12, 8'h04};
      5'd3:  e = {8'h11, 8'h00};
      5'd4:  e = {8'h0C, 8'h00};
      5'd5:  e = {8'h3E, 8'h00};
      5'd6:  e = {8'h8C, 8'h02};
      5'd7:  e = {8'h04, 8'h00};
      5'd8:  e = {8'h40, 8'hD0};
      5'd9:  e = {8'h3A, 8'h04};
      5'd10: e = {8'h14, 8'h18};
      5'd11: e = {8'h4F, 8'hB3};
      5'd12: e = {8'h50, 8'hB3};
      5'd13: e = {8'h51, 8'h00};
      5'd14: e = {8'h52, 8'h3D};
      5'd15: e = {8'h53, 8'hA7};
      5'd16: e = {8'h54, 8'hE4};
      5'd17: e = {8'h3D, 8'hC0};
`ifdef OV7670_TEST_PATTERN_EN
      5'd18: e = {8'h70, 8'h3A};
      5'd19: e = {8'h71, 8'hB5};
`endif
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/ov7670_init_if.sv
// Control handshake between the capture stage and the camera init sequencer.
interface ov7670_init_if;
  logic i_start;
  logic o_finish;
  logic o_busy;

  modport master (output i_start, input o_finish, input o_busy);
  modport slave  (input i_start, output o_finish, output o_busy);
endinterface

// File: rtl/ov7670_init_sccb_writer.sv
// One SCCB 3-phase write (ID, reg, data) with quarter-period SIOC timing.
module ov7670_init_sccb_writer
  import ov7670_init_pkg::*;
#(
  parameter int SCCB_QTR = 125
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  sccb_entry_t entry,
  output logic        done,
  output logic        sioc,
  output logic        siod_oe
);
  localparam int QW = (SCCB_QTR > 1) ? $clog2(SCCB_QTR) : 1;

  wr_state_t     state, nxt;
  logic [QW-1:0] div;
  logic [1:0]    qtr;
  logic [4:0]    bit_idx;
  logic [26:0]   frame;
  logic          tick, last_q;

  assign tick   = (div == QW'(SCCB_QTR - 1));
  assign last_q = tick && (qtr == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= W_IDLE;
      div     <= '0;
      qtr     <= '0;
      bit_idx <= '0;
      frame   <= '0;
    end else begin
      state <= nxt;
      if (state == W_IDLE) begin
        div     <= '0;
        qtr     <= '0;
        bit_idx <= '0;
        // Don't-care bits are 1 so SIOD is released on them.
        if (go) frame <= {SCCB_DEV_ID, 1'b1, entry.addr, 1'b1, entry.data, 1'b1};
      end else begin
        div <= tick ? '0 : div + 1'b1;
        if (tick) qtr <= qtr + 1'b1;
        if (last_q && state == S_BIT) begin
          bit_idx <= bit_idx + 1'b1;
          frame   <= {frame[25:0], 1'b1};
        end
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      W_IDLE:  if (go) nxt = S_START;
      S_START: if (last_q) nxt = S_BIT;
      S_BIT:   if (last_q && bit_idx == 5'd26) nxt = S_STOP;
      S_STOP:  if (last_q) nxt = W_IDLE;
      default: nxt = W_IDLE;
    endcase
  end

  always_comb begin
    sioc    = 1'b1;
    siod_oe = 1'b0;
    done    = 1'b0;
    case (state)
      S_START: siod_oe = qtr[1];
      S_BIT: begin
        sioc    = qtr[1];
        siod_oe = ~frame[26];
      end
      S_STOP: begin
        sioc    = (qtr != 2'd0);
        siod_oe = ~qtr[1];
        done    = last_q;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ov7670_init.sv
// OV7670 power-up sequencer: camera pins, settle/gap delays and the register-table walk.
// Build option: OV7670_TEST_PATTERN_EN (see ov7670_init_pkg).
module ov7670_init
  import ov7670_init_pkg::*;
#(
  parameter int SCCB_QTR   = 125,
  parameter int SETTLE_CYC = 50_000,
  parameter int GAP_CYC    = 500
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  ov7670_init_if.slave ctl,
  output logic         ov7670_xclk,
  output logic         ov7670_sioc,
  inout  wire          ov7670_siod,
  output logic         ov7670_pwdn,
  output logic         ov7670_reset
);
  localparam int MAXW = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
  localparam int CW   = $clog2(MAXW + 1);

  state_t           state, nxt;
  logic [IDX_W-1:0] idx;
  logic [CW-1:0]    cnt;
  logic             powered, xclk, accept, go, w_done, w_sioc, w_oe, is_delay, at_end;
  sccb_entry_t      entry;

  assign entry    = sccb_rom(idx);
  assign is_delay = (entry.addr == DELAY_REG);
  assign at_end   = (idx == IDX_W'(TABLE_LEN));
  assign accept   = ctl.i_start && (state == S_IDLE || state == S_DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      cnt     <= '0;
      powered <= 1'b0;
      xclk    <= 1'b0;
    end else begin
      state <= nxt;
      xclk  <= ~xclk;
      cnt   <= (nxt != state) ? '0 : cnt + 1'b1;
      if (accept) begin
        idx     <= '0;
        powered <= 1'b1;
      end else if ((state == S_LOAD && !at_end && is_delay) || w_done) begin
        idx <= idx + 1'b1;
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE: if (ctl.i_start) nxt = S_SETTLE;
      S_SETTLE:       if (cnt == CW'(SETTLE_CYC - 1)) nxt = S_LOAD;
      S_LOAD:         nxt = at_end ? S_DONE : (is_delay ? S_SETTLE : S_XFER);
      // Finish straight out of the last STOP rather than after a trailing gap.
      S_XFER:         if (w_done) nxt = (idx == IDX_W'(TABLE_LEN - 1)) ? S_DONE : S_GAP;
      S_GAP:          if (cnt == CW'(GAP_CYC - 1)) nxt = S_LOAD;
      default:        nxt = S_IDLE;
    endcase
  end

  always_comb begin
    go           = (state == S_LOAD) && !at_end && !is_delay;
    ctl.o_busy   = (state != S_IDLE) && (state != S_DONE);
    ctl.o_finish = (state == S_DONE);
  end

  ov7670_init_sccb_writer #(.SCCB_QTR(SCCB_QTR)) u_sccb_writer (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .go      (go),
    .entry   (entry),
    .done    (w_done),
    .sioc    (w_sioc),
    .siod_oe (w_oe)
  );

  assign ov7670_xclk  = xclk;
  assign ov7670_sioc  = w_sioc;
  assign ov7670_siod  = w_oe ? 1'b0 : 1'bz;
  assign ov7670_pwdn  = ~powered;
  assign ov7670_reset = powered;

endmodule

// File: tb/tb_ov7670_init.sv
// Scoreboard bench: SCCB bus decoder checks every write against a table-walk model.
module tb_ov7670_init;
  localparam int QTR    = 4;
  localparam int SETTLE = 200;
  localparam int GAP    = 20;
  localparam int BUDGET = 20000;

  typedef struct {
    logic [23:0] word;
    int          gap_min;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic xclk, sioc, pwdn, cam_rst;
  wire  siod;
  pullup (siod);

  ov7670_init_if ctl ();

  ov7670_init #(.SCCB_QTR(QTR), .SETTLE_CYC(SETTLE), .GAP_CYC(GAP)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .ctl          (ctl),
    .ov7670_xclk  (xclk),
    .ov7670_sioc  (sioc),
    .ov7670_siod  (siod),
    .ov7670_pwdn  (pwdn),
    .ov7670_reset (cam_rst)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  int          cyc = 0;
  exp_t        sb[$];
  logic [15:0] tab[$];
  int          n_writes;
  int          run_txn = 0, nb = 0, acc_cyc = 0, last_stop = 0, st_cyc = 0;
  bit          active = 0, want_first = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: walk the table; 0xFF entries are settle delays, others are writes.
  task automatic push_run();
    int gm = 0;
    foreach (tab[i]) begin
      if (tab[i][15:8] == 8'hFF) gm = SETTLE;
      else begin
        sb.push_back('{{8'h42, tab[i]}, gm});
        gm = GAP;
      end
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1 ctl.i_start = 1'b1;
    @(posedge clk); #1 ctl.i_start = 1'b0;
    acc_cyc    = cyc;
    want_first = 1;
    run_txn    = 0;
    push_run();
    check("pwdn_after_start", pwdn, 0);
    check("cam_reset_after_start", cam_rst, 1);
    check("busy_after_start", ctl.o_busy, 1);
    check("finish_cleared", ctl.o_finish, 0);
  endtask

  task automatic wait_finish(input string nm);
    int t = 0;
    while (!ctl.o_finish && t < BUDGET) begin @(posedge clk); #1 t++; end
    check(nm, ctl.o_finish, 1);
    check({nm, "_writes"}, run_txn, n_writes);
    check({nm, "_busy_low"}, ctl.o_busy, 0);
  endtask

  task automatic wait_txn(input int n, input int bits, input string nm);
    int t = 0;
    while (!(run_txn == n && (bits == 0 || (active && nb >= bits))) && t < BUDGET) begin
      @(posedge clk); t++;
    end
    check(nm, t < BUDGET, 1);
  endtask

  // Bus monitor: decodes START / bits on SIOC rise / STOP, and pops the scoreboard.
  initial begin
    logic        ps = 1'b1, pd = 1'b1, pf = 1'b0;
    logic [27:0] sh = '0;
    logic [26:0] w;
    exp_t        e;
    int          d;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        active = 0;
        pf     = 1'b0;
      end else begin
        if (ps && sioc && pd && !siod) begin
          active = 1; nb = 0; sh = '0; st_cyc = cyc;
          if (want_first) begin
            d = st_cyc - acc_cyc;
            check("first_start_window", (d >= SETTLE) && (d <= SETTLE + 2 + 4 * QTR), 1);
            want_first = 0;
          end
        end else if (active && !ps && sioc) begin
          sh = {sh[26:0], siod};
          nb++;
        end else if (active && ps && sioc && !pd && siod) begin
          active = 0;
          check("frame_edges", nb, 28);
          w = sh[27:1];
          if (sb.size() == 0) check("unexpected_write", {w[26:19], w[17:10], w[8:1]}, 0);
          else begin
            e = sb.pop_front();
            check("write_word", {w[26:19], w[17:10], w[8:1]}, e.word);
            check("ack_bits_released", {w[18], w[9], w[0]}, 3'b111);
            if (e.gap_min > 0) check("idle_gap", (st_cyc - last_stop) >= e.gap_min, 1);
          end
          last_stop = cyc;
          run_txn++;
        end
        if (!pf && ctl.o_finish) begin
          check("finish_after_stop", cyc - last_stop, 2 * QTR);
          check("scoreboard_drained", sb.size(), 0);
        end
        pf = ctl.o_finish;
      end
      ps = sioc;
      pd = siod;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    tab = '{16'h1280, 16'hFFFF, 16'h1204, 16'h1100, 16'h0C00, 16'h3E00, 16'h8C02,
            16'h0400, 16'h40D0, 16'h3A04, 16'h1418, 16'h4FB3, 16'h50B3, 16'h5100,
            16'h523D, 16'h53A7, 16'h54E4, 16'h3DC0};
`ifdef OV7670_TEST_PATTERN_EN
    tab.push_back(16'h703A);
    tab.push_back(16'h71B5);
`endif
    n_writes = 0;
    foreach (tab[i]) if (tab[i][15:8] != 8'hFF) n_writes++;

    rst_n = 1'b0;
    ctl.i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_finish", ctl.o_finish, 0);
    check("rst_busy", ctl.o_busy, 0);
    check("rst_xclk", xclk, 0);
    check("rst_sioc", sioc, 1);
    check("rst_siod_released", siod, 1);
    check("rst_pwdn", pwdn, 1);
    check("rst_cam_reset", cam_rst, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) a = xclk;
    @(negedge clk) check("xclk_toggle", xclk, !a);
    check("idle_pwdn", pwdn, 1);

    // Full run.
    repeat ($urandom_range(2, 10)) @(posedge clk);
    do_start();
    wait_finish("run1_finish");

    // Rerun from DONE with a start pulse mid-table that must be ignored.
    repeat ($urandom_range(1, 30)) @(posedge clk);
    do_start();
    wait_txn($urandom_range(3, n_writes - 3), 0, "midstart_reach");
    @(posedge clk); #1 ctl.i_start = 1'b1;
    @(posedge clk); #1 ctl.i_start = 1'b0;
    check("midstart_busy", ctl.o_busy, 1);
    check("midstart_finish", ctl.o_finish, 0);
    wait_finish("run2_finish");

    // Asynchronous reset inside bit 13 of transaction 3.
    do_start();
    wait_txn(3, 13, "abort_reach");
    #($urandom_range(1, 8));
    rst_n = 1'b0;
    #1;
    check("abort_sioc", sioc, 1);
    check("abort_siod_released", siod, 1);
    check("abort_pwdn", pwdn, 1);
    check("abort_cam_reset", cam_rst, 0);
    check("abort_busy", ctl.o_busy, 0);
    sb.delete();
    want_first = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Rerun from entry 0 after the abort.
    repeat ($urandom_range(2, 10)) @(posedge clk);
    do_start();
    wait_finish("run4_finish");

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
